// File: rtl/woble_ps_stepper.sv
// Dynamic phase-shift stepper for the wobble-clock MMCM: one psen per step, tracks signed position.
// Optional macro WOBLE_PS_STEP_LIMIT_EN adds a |ps_pos| <= MAX_POS guard and the limit_hit output.
module woble_ps_stepper #(
  parameter int unsigned POS_W          = 16,
  parameter int unsigned PSDONE_TIMEOUT = 64,
  parameter int unsigned STEP_GAP       = 2
`ifdef WOBLE_PS_STEP_LIMIT_EN
  ,
  parameter int unsigned MAX_POS        = 4096
`endif
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    woble_clk_ps_data_flag,
  input  logic [13:0]             woble_clk_ps_data,
  output logic                    psen,
  output logic                    psincdec,
  input  logic                    psdone,
  output logic                    busy,
  output logic                    cmd_done,
  output logic                    cmd_drop,
  output logic                    ps_err,
`ifdef WOBLE_PS_STEP_LIMIT_EN
  output logic                    limit_hit,
`endif
  output logic signed [POS_W-1:0] ps_pos
);

  localparam int unsigned EXT_W = POS_W + 1;
  localparam int unsigned TMO_W = $clog2(PSDONE_TIMEOUT + 1);
  localparam int unsigned GAP_W = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PSDONE_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((STEP_GAP > 0) ? STEP_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

  state_t                   state_q, state_nxt;
  logic                     dir_q, dir_nxt;
  logic [POS_W-1:0]         rem_q, rem_dec, cmd_cnt;
  logic signed [POS_W-1:0]  pos_q, pos_nxt;
  logic signed [EXT_W-1:0]  pos_ext, pos_abs;
  logic [TMO_W-1:0]         tmo_q;
  logic [GAP_W-1:0]         gap_q;
  logic                     strobe_ok, home, cmd_dir, step_done, timeout, gap_end, over;
  logic                     go_issue, fin, lim;
  logic                     psen_d, psincdec_d, busy_d, done_d, drop_d, err_d, lim_d;

  // Command decode and per-step datapath values
  always_comb begin
    strobe_ok = woble_clk_ps_data_flag & ~busy;
    home      = woble_clk_ps_data[12];
    pos_ext   = EXT_W'(pos_q);
    pos_abs   = pos_q[POS_W-1] ? -pos_ext : pos_ext;
    cmd_dir   = home ? pos_q[POS_W-1] : woble_clk_ps_data[13];
    cmd_cnt   = home ? POS_W'(pos_abs) : POS_W'(woble_clk_ps_data[11:0]);
    step_done = (state_q == WAIT_DONE) && psdone;
    timeout   = (state_q == WAIT_DONE) && !psdone && (tmo_q == TMO_LAST);
    gap_end   = (state_q == GAP) && (gap_q == GAP_LAST);
    rem_dec   = rem_q - POS_W'(1);
    dir_nxt   = strobe_ok ? cmd_dir : dir_q;
    pos_nxt   = pos_q;
    if (step_done)
      pos_nxt = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
  end

`ifdef WOBLE_PS_STEP_LIMIT_EN
  localparam int unsigned LIM_W = POS_W + 2;
  localparam logic signed [LIM_W-1:0] LIM_HI = LIM_W'(MAX_POS);
  localparam logic signed [LIM_W-1:0] LIM_LO = -LIM_HI;
  logic signed [LIM_W-1:0] pos_lim;

  // Would the step about to be issued push |ps_pos| past MAX_POS
  always_comb begin
    pos_lim = LIM_W'(pos_nxt);
    over    = dir_nxt ? ((pos_lim + LIM_W'(1)) > LIM_HI) : ((pos_lim - LIM_W'(1)) < LIM_LO);
  end
`else
  assign over = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    go_issue  = 1'b0;
    fin       = 1'b0;
    lim       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (strobe_ok) begin
          if (cmd_cnt == '0) fin = 1'b1;
          else               go_issue = 1'b1;
        end
      end
      ISSUE: state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (psdone) begin
          if (rem_dec == '0) begin
            fin       = 1'b1;
            state_nxt = IDLE;
          end else if (STEP_GAP > 0) begin
            state_nxt = GAP;
          end else begin
            go_issue = 1'b1;
          end
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      GAP: if (gap_end) go_issue = 1'b1;
      default: state_nxt = IDLE;
    endcase
    // Every route into ISSUE passes the position guard
    if (go_issue) begin
      if (over) begin
        state_nxt = IDLE;
        fin       = 1'b1;
        lim       = 1'b1;
      end else begin
        state_nxt = ISSUE;
      end
    end
  end

  // busy stays high through the cmd_done cycle so a strobe there is dropped
  always_comb begin
    psen_d     = (state_nxt == ISSUE);
    psincdec_d = (state_nxt == ISSUE) ? dir_nxt : psincdec;
    busy_d     = (state_nxt != IDLE) | fin;
    done_d     = fin;
    drop_d     = woble_clk_ps_data_flag & busy;
    err_d      = timeout;
    lim_d      = lim;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= 1'b0;
      rem_q <= '0;
      pos_q <= '0;
      tmo_q <= '0;
      gap_q <= '0;
    end else begin
      dir_q <= dir_nxt;
      if (state_nxt == IDLE) rem_q <= '0;
      else if (strobe_ok)    rem_q <= cmd_cnt;
      else if (step_done)    rem_q <= rem_dec;
      pos_q <= pos_nxt;
      tmo_q <= (state_q == WAIT_DONE) ? tmo_q + TMO_W'(1) : '0;
      gap_q <= (state_q == GAP) ? gap_q + GAP_W'(1) : '0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      psen     <= 1'b0;
      psincdec <= 1'b0;
      busy     <= 1'b0;
      cmd_done <= 1'b0;
      cmd_drop <= 1'b0;
      ps_err   <= 1'b0;
    end else begin
      psen     <= psen_d;
      psincdec <= psincdec_d;
      busy     <= busy_d;
      cmd_done <= done_d;
      cmd_drop <= drop_d;
      ps_err   <= err_d;
    end
  end

`ifdef WOBLE_PS_STEP_LIMIT_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) limit_hit <= 1'b0;
    else        limit_hit <= lim_d;
  end
`else
  logic unused_lim;
  assign unused_lim = lim_d;
`endif

  assign ps_pos = pos_q;

endmodule

// File: tb/tb_woble_ps_stepper.sv
// Self-checking bench for woble_ps_stepper: command table, MMCM psdone model and completion scoreboard.
`timescale 1ns/1ps
module tb_woble_ps_stepper;

  localparam int POS_W  = 16;
  localparam int TMO    = 64;
  localparam int GAP    = 2;
  localparam int LAT    = 12;
  localparam int PERIOD = 1 + LAT + GAP;
  localparam int NV     = 8;

  logic                    sys_clk = 1'b0;
  logic                    rst_n;
  logic                    flag;
  logic [13:0]             data;
  logic                    psen, psincdec, psdone, busy, cmd_done, cmd_drop, ps_err;
  logic signed [POS_W-1:0] ps_pos;
`ifdef WOBLE_PS_STEP_LIMIT_EN
  logic                    limit_hit;
`endif

  typedef struct {
    logic [13:0] data;
    int          mute;
    int          n;
    logic        dir;
    int          pos;
    logic        err;
    logic        lim;
  } vec_t;

  typedef struct {
    vec_t v;
    int   start;
    int   lat;
  } exp_t;

  vec_t vecs[NV];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   psen_total = 0;
  int   model_idx  = 0;
  int   mute_idx   = -1;
  int   cmd_psen   = 0;
  int   last_psen  = 0;

  woble_ps_stepper #(
    .POS_W(POS_W), .PSDONE_TIMEOUT(TMO), .STEP_GAP(GAP)
`ifdef WOBLE_PS_STEP_LIMIT_EN
    , .MAX_POS(4)
`endif
  ) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .woble_clk_ps_data_flag(flag),
    .woble_clk_ps_data(data),
    .psen(psen),
    .psincdec(psincdec),
    .psdone(psdone),
    .busy(busy),
    .cmd_done(cmd_done),
    .cmd_drop(cmd_drop),
    .ps_err(ps_err),
`ifdef WOBLE_PS_STEP_LIMIT_EN
    .limit_hit(limit_hit),
`endif
    .ps_pos(ps_pos)
  );

  always #5 sys_clk = ~sys_clk;

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input vec_t v);
    if (v.err)    return PERIOD * (v.n - 1) + TMO + 2;
    if (v.lim)    return PERIOD * v.n + 1;
    if (v.n == 0) return 1;
    return PERIOD * v.n - 1;
  endfunction

  // MMCM model: psdone LAT cycles after each psen, except the muted step
  initial begin
    psdone = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (psen && rst_n) begin
        model_idx++;
        if (model_idx != mute_idx) begin
          repeat (LAT) @(negedge sys_clk);
          psdone = 1'b1;
          @(negedge sys_clk);
          psdone = 1'b0;
        end
      end
    end
  end

  // Monitor: per-psen direction/spacing checks, completion popped from the scoreboard
  initial forever begin
    exp_t e;
    @(negedge sys_clk);
    if (!rst_n) begin
      cmd_psen = 0;
    end else begin
      if (psen) begin
        psen_total++;
        if (sb.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_psen: psen=1 with no command pending (cycle %0d)", cyc);
        end else begin
          chk("psincdec_at_psen", int'(psincdec), int'(sb[0].v.dir));
          if (cmd_psen > 0) chk("psen_spacing", cyc - last_psen, PERIOD);
        end
        cmd_psen++;
        last_psen = cyc;
      end
      if (cmd_done || ps_err) begin
        if (sb.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_completion: done=%0d err=%0d with no command pending", cmd_done, ps_err);
        end else begin
          e = sb.pop_front();
          chk("ps_err", int'(ps_err), int'(e.v.err));
          chk("cmd_done", int'(cmd_done), int'(!e.v.err));
          chk("psen_count", cmd_psen, e.v.n);
          chk("ps_pos", int'(ps_pos), e.v.pos);
          chk("latency", cyc - e.start, e.lat);
          chk("busy_at_end", int'(busy), int'(!e.v.err));
`ifdef WOBLE_PS_STEP_LIMIT_EN
          chk("limit_hit", int'(limit_hit), int'(e.v.lim));
`endif
        end
        cmd_psen = 0;
      end
    end
  end

  task automatic wait_idle();
    int i;
    i = 0;
    while ((sb.size() != 0 || busy) && i < 5000) begin
      @(negedge sys_clk);
      i++;
    end
    if (i >= 5000) begin
      n_checks++; n_err++;
      $display("FAIL wait_idle: busy=%0d pending=%0d after 5000 cycles", busy, sb.size());
    end
  endtask

  task automatic send(input vec_t v);
    exp_t e;
    wait_idle();
    @(negedge sys_clk);
    data  = v.data;
    flag  = 1'b1;
    e.v     = v;
    e.start = cyc;
    e.lat   = lat_of(v);
    sb.push_back(e);
    @(negedge sys_clk);
    flag = 1'b0;
    chk("busy_after_strobe", int'(busy), 1);
  endtask

  initial begin
    int   p0, i;
    vec_t v;
    // data, mute step, psen count, dir, final pos, err, limit
    vecs[0] = '{data:{1'b1, 1'b0, 12'd3},   mute:0, n:3, dir:1'b1, pos:3,  err:1'b0, lim:1'b0};
    vecs[1] = '{data:{1'b0, 1'b0, 12'd5},   mute:0, n:5, dir:1'b0, pos:-2, err:1'b0, lim:1'b0};
    vecs[2] = '{data:{1'b0, 1'b1, 12'd600}, mute:0, n:2, dir:1'b1, pos:0,  err:1'b0, lim:1'b0};
    vecs[3] = '{data:{1'b1, 1'b0, 12'd0},   mute:0, n:0, dir:1'b0, pos:0,  err:1'b0, lim:1'b0};
    vecs[4] = '{data:{1'b1, 1'b1, 12'd7},   mute:0, n:0, dir:1'b0, pos:0,  err:1'b0, lim:1'b0};
    vecs[5] = '{data:{1'b1, 1'b0, 12'd4},   mute:2, n:2, dir:1'b1, pos:1,  err:1'b1, lim:1'b0};
    vecs[6] = '{data:{1'b0, 1'b0, 12'd2},   mute:0, n:2, dir:1'b0, pos:-1, err:1'b0, lim:1'b0};
    vecs[7] = '{data:{1'b0, 1'b1, 12'd9},   mute:0, n:1, dir:1'b1, pos:0,  err:1'b0, lim:1'b0};

    rst_n = 1'b0;
    flag  = 1'b0;
    data  = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_psen", int'(psen), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cmd_done", int'(cmd_done), 0);
    chk("rst_cmd_drop", int'(cmd_drop), 0);
    chk("rst_ps_err", int'(ps_err), 0);
    chk("rst_ps_pos", int'(ps_pos), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    for (int k = 0; k < NV; k++) begin
      wait_idle();
      if (vecs[k].mute > 0) mute_idx = model_idx + vecs[k].mute;
      send(vecs[k]);
      wait_idle();
      repeat (2) @(negedge sys_clk);
    end

    // Strobe during WAIT_DONE is dropped; original count still runs
    v = '{data:{1'b1, 1'b0, 12'd2}, mute:0, n:2, dir:1'b1, pos:2, err:1'b0, lim:1'b0};
    send(v);
    repeat (4) @(negedge sys_clk);
    data = {1'b0, 1'b0, 12'd7};
    flag = 1'b1;
    @(negedge sys_clk);
    flag = 1'b0;
    chk("drop_in_wait", int'(cmd_drop), 1);
    chk("busy_in_wait", int'(busy), 1);

    // Strobe in the cmd_done cycle is dropped too
    i = 0;
    while (!cmd_done && i < 200) begin
      @(negedge sys_clk);
      i++;
    end
    chk("done_seen", int'(cmd_done), 1);
    data = {1'b1, 1'b0, 12'd1};
    flag = 1'b1;
    @(negedge sys_clk);
    flag = 1'b0;
    chk("drop_in_done", int'(cmd_drop), 1);
    chk("idle_after_drop", int'(busy), 0);
    p0 = psen_total;
    repeat (20) @(negedge sys_clk);
    chk("no_psen_after_drop", psen_total, p0);
    chk("pos_after_drop", int'(ps_pos), 2);

    // Reset mid-command aborts at once and clears position
    v = '{data:{1'b1, 1'b0, 12'd3}, mute:0, n:3, dir:1'b1, pos:5, err:1'b0, lim:1'b0};
    p0 = psen_total;
    send(v);
    repeat (6) @(negedge sys_clk);
    chk("psen_before_reset", psen_total, p0 + 1);
    rst_n = 1'b0;
    @(negedge sys_clk);
    sb.delete();
    chk("reset_psen", int'(psen), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pos", int'(ps_pos), 0);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    p0 = psen_total;
    repeat (40) @(negedge sys_clk);
    chk("no_psen_after_reset", psen_total, p0);
    chk("pos_after_reset", int'(ps_pos), 0);
    chk("busy_after_reset", int'(busy), 0);

`ifdef WOBLE_PS_STEP_LIMIT_EN
    // MAX_POS = 4: six increments stop after four
    v = '{data:{1'b1, 1'b0, 12'd6}, mute:0, n:4, dir:1'b1, pos:4, err:1'b0, lim:1'b1};
    send(v);
    wait_idle();
    v = '{data:{1'b1, 1'b1, 12'd0}, mute:0, n:4, dir:1'b0, pos:0, err:1'b0, lim:1'b0};
    send(v);
    wait_idle();
`endif

    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
